pfd_model: RTL and testbench
============================

PFD_MODEL -- requirements
Module: pfd_model

Interface
REQ-001 Reset RESET_, asynchronous, active-low.
REQ-002 RESET_  input  1  asynchronous active-low reset; low forces both flags to 0.
REQ-003 IN  input  1  reference clock; rising edge is the reference phase event.
REQ-004 FB  input  1  feedback clock; rising edge is the feedback phase event.
REQ-005 flagU  output  1  UP pulse; IN edge ahead of FB edge (FB lags).
REQ-006 flagD  output  1  DOWN pulse; FB edge ahead of IN edge (FB leads).
REQ-007 Parameter RST_DLY_PS, 50, delay in ps from both internal flags being set to both being cleared.
REQ-008 Parameter DEADZONE_PS, 20, minimum internal pulse width in ps before a flag is shown (used only with PFD_DEADZONE_EN).

Function
REQ-009 The block SHALL be a tri-state phase-frequency detector with two internal state bits, up_q and dn_q.
REQ-010 A rising IN SHALL set up_q; a rising FB SHALL set dn_q; an edge on an already-set bit SHALL have no effect.
REQ-011 When up_q and dn_q are both 1, both SHALL clear together exactly RST_DLY_PS later.
REQ-012 Edges arriving during the clear window SHALL be ignored (clear dominates).
REQ-013 Simultaneous IN and FB rising edges SHALL set both bits; both flags then pulse for RST_DLY_PS.
REQ-014 Phase error: leading-side flag width SHALL equal edge separation plus RST_DLY_PS; trailing-side flag width SHALL equal RST_DLY_PS.
REQ-015 Frequency error: repeated edges on one input without the other SHALL hold that flag high continuously until the other edge arrives.
REQ-016 Without PFD_DEADZONE_EN: flagU = up_q and flagD = dn_q, with zero added delay.
REQ-017 Each flag SHALL produce exactly one falling edge per clear event, with no glitches.

Reset
REQ-018 RESET_ low SHALL clear up_q, dn_q, any pending clear and both flags immediately.
REQ-019 While RESET_ is low, IN and FB edges SHALL be ignored.
REQ-020 RESET_ low during a pulse SHALL end that pulse immediately.
REQ-021 After RESET_ rises, the first rising edge of either input SHALL be treated as a fresh event.

Configuration
REQ-022 Macro PFD_DEADZONE_EN SHALL control the dead-zone filter.
REQ-023 With PFD_DEADZONE_EN defined: a flag SHALL assert only once its internal bit has stayed high for DEADZONE_PS, and SHALL deassert when the bit clears.
REQ-024 With PFD_DEADZONE_EN defined: internal pulses no longer than DEADZONE_PS SHALL produce no flag activity.
REQ-025 Without PFD_DEADZONE_EN: no filtering, behaviour per REQ-016.

Structure
REQ-026 Shared package pfd_pkg SHALL hold the default RST_DLY_PS and DEADZONE_PS constants and the per-channel flag state typedef (IDLE, ACTIVE, CLEARING).
REQ-027 Sub-module pfd_edge_latch (edge-set, clear-reset, async reset, optional dead-zone filter) SHALL be instantiated once for IN/flagU and once for FB/flagD.
REQ-028 The top level SHALL contain only the AND-and-delay clear logic and the two latch instances.

Verification
REQ-029 IN = 25 MHz (40 ns period), FB = IN delayed 58 ps, defaults, no macro -> every period flagU high 108 ps and flagD high 50 ps, both falling together.
REQ-030 Same stimulus with IN and FB swapped -> flagD high 108 ps and flagU high 50 ps.
REQ-031 IN and FB identical -> both flags pulse 50 ps each cycle, no width asymmetry.
REQ-032 IN period 20 ns, FB period 40 ns -> flagU high about 50 % of the time or more, rising every FB cycle; flagD pulses only 50 ps.
REQ-033 RESET_ driven low 30 ps into a flagU pulse -> both flags 0 within 0 ps; no activity until RESET_ rises and the next rising edge occurs.
REQ-034 PFD_DEADZONE_EN with DEADZONE_PS = 60 and the REQ-029 stimulus -> flagU asserts 60 ps after the IN edge for 48 ps; flagD stays 0.

Source files
------------

// File: rtl/pfd_pkg.sv
`timescale 1ps/1fs
// Shared constants and types for the tri-state phase-frequency detector.
// Delays are counted on a free-running time-base clock of TICK_PS per cycle.
package pfd_pkg;

   localparam int PFD_RST_DLY_PS  = 50;
   localparam int PFD_DEADZONE_PS = 20;
   localparam int PFD_TICK_PS     = 1;

   // Per-channel flag state, exposed for observation.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACTIVE   = 2'd1,
      CLEARING = 2'd2
   } pfd_state_e;

   // Delay in time-base ticks, never less than one tick.
   function automatic int pfd_ticks(input int dly_ps, input int tick_ps);
      return ((dly_ps / tick_ps) < 1) ? 1 : (dly_ps / tick_ps);
   endfunction

   // Counter width able to hold the larger of two tick counts.
   function automatic int pfd_cnt_w(input int a, input int b);
      return $clog2(((a > b) ? a : b) + 1);
   endfunction

endpackage

// File: rtl/pfd_model_if.sv
`timescale 1ps/1fs
// Phase inputs, UP/DOWN flags and per-channel debug state of the PFD.
// The master drives the IN/FB phase events; the slave (detector) returns the flags.
interface pfd_model_if;
   import pfd_pkg::*;

   logic       IN;
   logic       FB;
   logic       flagU;
   logic       flagD;
   pfd_state_e state_u;
   pfd_state_e state_d;

   modport master (output IN, FB, input flagU, flagD, state_u, state_d);
   modport slave  (input IN, FB, output flagU, flagD, state_u, state_d);

endinterface

// File: rtl/pfd_edge_latch.sv
`timescale 1ps/1fs
// One PFD channel: rising i_edge sets the state bit, i_clr or RESET_ clears it.
// Optional dead-zone filter (PFD_DEADZONE_EN) hides pulses shorter than DZ_TICKS.
module pfd_edge_latch
   import pfd_pkg::*;
`ifdef PFD_DEADZONE_EN
#(
   parameter int DZ_TICKS = PFD_DEADZONE_PS,
   parameter int CW       = 5
)
`endif
(
   input  logic       RESET_,
   input  logic       i_edge,
   input  logic       i_clr,
`ifdef PFD_DEADZONE_EN
   input  logic       i_tclk,
`endif
   output logic       o_q,
   output logic       o_flag,
   output pfd_state_e o_state
);

   logic w_rst_n;
   logic r_q;

   // Clear dominates: while it is held, edges on i_edge cannot set the bit.
   assign w_rst_n = RESET_ & ~i_clr;

   always_ff @(posedge i_edge or negedge w_rst_n) begin
      if (!w_rst_n) r_q <= 1'b0;
      else          r_q <= 1'b1;
   end

   assign o_q = r_q;

`ifdef PFD_DEADZONE_EN
   logic [CW-1:0] r_dz_cnt;
   logic          r_dz_ok;

   // Counts on falling ticks so the rising-tick qualifier lands exactly DZ_TICKS after the set.
   always_ff @(negedge i_tclk or negedge w_rst_n) begin
      if (!w_rst_n)                                 r_dz_cnt <= '0;
      else if (r_q && (r_dz_cnt != CW'(DZ_TICKS)))  r_dz_cnt <= r_dz_cnt + CW'(1);
   end

   always_ff @(posedge i_tclk or negedge w_rst_n) begin
      if (!w_rst_n) r_dz_ok <= 1'b0;
      else          r_dz_ok <= r_q && (r_dz_cnt == CW'(DZ_TICKS));
   end

   assign o_flag = r_q & r_dz_ok;
`else
   assign o_flag = r_q;
`endif

   always_comb begin
      o_state = IDLE;
      if (i_clr)    o_state = CLEARING;
      else if (r_q) o_state = ACTIVE;
   end

endmodule

// File: rtl/pfd_model.sv
`timescale 1ps/1fs
// Tri-state PFD: two edge latches plus the AND-and-delay clear path.
// Define PFD_DEADZONE_EN to enable the per-flag dead-zone filter.
module pfd_model
   import pfd_pkg::*;
#(
   parameter int RST_DLY_PS  = PFD_RST_DLY_PS,
   parameter int DEADZONE_PS = PFD_DEADZONE_PS,
   parameter int TICK_PS     = PFD_TICK_PS
)(
   input  logic       RESET_,
   input  logic       i_tclk,
   pfd_model_if.slave bus
);

   localparam int CLR_TICKS = pfd_ticks(RST_DLY_PS, TICK_PS);
   localparam int DZ_TICKS  = pfd_ticks(DEADZONE_PS, TICK_PS);
   // One width serves both the clear counter and the dead-zone counters.
   localparam int CW        = pfd_cnt_w(CLR_TICKS, DZ_TICKS);

   logic          w_up_q;
   logic          w_dn_q;
   logic          w_both;
   logic [CW-1:0] r_cnt;
   logic          r_clr;

   assign w_both = w_up_q & w_dn_q;

   // Falling ticks measure how long both bits have been set; the rising tick
   // then fires the clear exactly CLR_TICKS after the second bit was set.
   always_ff @(negedge i_tclk or negedge RESET_) begin
      if (!RESET_)                           r_cnt <= '0;
      else if (!w_both)                      r_cnt <= '0;
      else if (r_cnt != CW'(CLR_TICKS))      r_cnt <= r_cnt + CW'(1);
   end

   always_ff @(posedge i_tclk or negedge RESET_) begin
      if (!RESET_) r_clr <= 1'b0;
      else         r_clr <= w_both && (r_cnt == CW'(CLR_TICKS));
   end

`ifdef PFD_DEADZONE_EN
   pfd_edge_latch #(.DZ_TICKS(DZ_TICKS), .CW(CW)) u_up (
      .RESET_  (RESET_),
      .i_edge  (bus.IN),
      .i_clr   (r_clr),
      .i_tclk  (i_tclk),
      .o_q     (w_up_q),
      .o_flag  (bus.flagU),
      .o_state (bus.state_u)
   );

   pfd_edge_latch #(.DZ_TICKS(DZ_TICKS), .CW(CW)) u_dn (
      .RESET_  (RESET_),
      .i_edge  (bus.FB),
      .i_clr   (r_clr),
      .i_tclk  (i_tclk),
      .o_q     (w_dn_q),
      .o_flag  (bus.flagD),
      .o_state (bus.state_d)
   );
`else
   pfd_edge_latch u_up (
      .RESET_  (RESET_),
      .i_edge  (bus.IN),
      .i_clr   (r_clr),
      .o_q     (w_up_q),
      .o_flag  (bus.flagU),
      .o_state (bus.state_u)
   );

   pfd_edge_latch u_dn (
      .RESET_  (RESET_),
      .i_edge  (bus.FB),
      .i_clr   (r_clr),
      .o_q     (w_dn_q),
      .o_flag  (bus.flagD),
      .o_state (bus.state_d)
   );
`endif

endmodule

// File: tb/tb_pfd_model.sv
`timescale 1ps/1fs
// Directed bench for pfd_model: lag, lead, equal phase, frequency error and reset.
// The 1 ps time-base clock only runs around phase events to keep the cycle count low.
module tb_pfd_model;
   import pfd_pkg::*;

`ifdef PFD_DEADZONE_EN
   localparam int DZ_PS = 60;
`else
   localparam int DZ_PS = PFD_DEADZONE_PS;
`endif

   logic RESET_;
   logic tclk;
   logic tick_en = 1'b0;

   pfd_model_if bus ();

   pfd_model #(.RST_DLY_PS(50), .DEADZONE_PS(DZ_PS), .TICK_PS(1)) dut (
      .RESET_ (RESET_),
      .i_tclk (tclk),
      .bus    (bus)
   );

   // Clock block: rising ticks on integer ps, falling ticks on half ps.
   initial begin
      tclk = 1'b1;
      forever begin
         wait (tick_en);
         #0.5 tclk = 1'b0;
         #0.5 tclk = 1'b1;
      end
   end

   // Flag edge monitors.
   realtime u_rise, u_fall, d_rise, d_fall, t_evt;
   int u_rises, u_falls, d_rises, d_falls;
   initial begin
      u_rise = 0; u_fall = 0; d_rise = 0; d_fall = 0; t_evt = 0;
      u_rises = 0; u_falls = 0; d_rises = 0; d_falls = 0;
   end
   always @(posedge bus.flagU) begin u_rise = $realtime; u_rises++; end
   always @(negedge bus.flagU) begin u_fall = $realtime; u_falls++; end
   always @(posedge bus.flagD) begin d_rise = $realtime; d_rises++; end
   always @(negedge bus.flagD) begin d_fall = $realtime; d_falls++; end

   // Scoreboard.
   logic [31:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int exp_nu   = 0;
   int exp_nd   = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   // Pops expected UP then DOWN width; one falling edge per flag per pulse.
   task automatic check_pulse(input string tag);
      exp_nu++;
      exp_nd++;
      chk({tag, "_nfall_u"}, u_falls, exp_nu);
      chk({tag, "_nfall_d"}, d_falls, exp_nd);
      chk({tag, "_width_u"}, int'(u_fall - u_rise), int'(exp_q.pop_front()));
      chk({tag, "_width_d"}, int'(d_fall - d_rise), int'(exp_q.pop_front()));
      chk({tag, "_fall_align"}, int'(d_fall - u_fall), 0);
   endtask

   // Driver: rising IN at +t_in and FB at +t_fb (-1 = no edge), tick running for span ps.
   task automatic drive_pair(input int t_in, input int t_fb, input int span);
      tick_en = 1'b1;
      t_evt   = $realtime;
      for (int k = 0; k < span; k++) begin
         if (k == t_in) bus.IN = 1'b1;
         if (k == t_fb) bus.FB = 1'b1;
         #1;
      end
      bus.IN  = 1'b0;
      bus.FB  = 1'b0;
      tick_en = 1'b0;
   endtask

   initial begin
      int d_before;
      RESET_ = 1'b0;
      bus.IN = 1'b0;
      bus.FB = 1'b0;
      #100;
      chk("reset_flagU", int'(bus.flagU), 0);
      chk("reset_flagD", int'(bus.flagD), 0);
      chk("reset_state_u", int'(bus.state_u), int'(IDLE));
      chk("reset_state_d", int'(bus.state_d), int'(IDLE));
      u_rises = 0; u_falls = 0; d_rises = 0; d_falls = 0;
      RESET_ = 1'b1;
      #100;

`ifdef PFD_DEADZONE_EN
      // FB lags 58 ps, dead zone 60 ps: UP shows from +60 to +108, DOWN never shows.
      drive_pair(0, 58, 300);
      chk("dz_width_u", int'(u_fall - u_rise), 48);
      chk("dz_rise_u", int'(u_rise - t_evt), 60);
      chk("dz_nrise_u", u_rises, 1);
      chk("dz_nrise_d", d_rises, 0);
      #39700;
      drive_pair(0, 58, 300);
      chk("dz2_width_u", int'(u_fall - u_rise), 48);
      chk("dz2_nrise_d", d_rises, 0);
`else
      // FB lags IN by 58 ps: UP 58+50, DOWN 50.
      for (int p = 0; p < 2; p++) begin
         drive_pair(0, 58, 300);
         exp_q.push_back(108);
         exp_q.push_back(50);
         check_pulse($sformatf("lag%0d", p));
         chk($sformatf("lag%0d_rise_d", p), int'(d_rise - t_evt), 58);
         #39700;
      end

      // FB leads IN by 58 ps: DOWN 108, UP 50.
      for (int p = 0; p < 2; p++) begin
         drive_pair(58, 0, 300);
         exp_q.push_back(50);
         exp_q.push_back(108);
         check_pulse($sformatf("lead%0d", p));
         #39700;
      end

      // Identical edges: both flags 50 ps.
      for (int p = 0; p < 2; p++) begin
         drive_pair(0, 0, 300);
         exp_q.push_back(50);
         exp_q.push_back(50);
         check_pulse($sformatf("equal%0d", p));
         #39700;
      end

      // Frequency error: IN at 20 ns, FB at 40 ns; UP holds from the lone IN edge.
      drive_pair(0, 0, 300);
      exp_q.push_back(50);
      exp_q.push_back(50);
      check_pulse("freq_start");
      for (int p = 0; p < 2; p++) begin
         #19700;
         drive_pair(0, -1, 300);
         chk($sformatf("freq%0d_hold_u", p), int'(bus.flagU), 1);
         chk($sformatf("freq%0d_idle_d", p), int'(bus.flagD), 0);
         chk($sformatf("freq%0d_state_u", p), int'(bus.state_u), int'(ACTIVE));
         #19700;
         drive_pair(0, 0, 300);
         exp_q.push_back(20050);
         exp_q.push_back(50);
         check_pulse($sformatf("freq%0d", p));
      end
      #1000;

      // Reset 30 ps into an UP pulse, edges ignored while low, fresh start after.
      tick_en = 1'b1;
      bus.IN  = 1'b1;
      #29.5;
      chk("rst_pre_u", int'(bus.flagU), 1);
      #0.5 RESET_ = 1'b0;
      #0.5;
      chk("rst_u_low", int'(bus.flagU), 0);
      chk("rst_d_low", int'(bus.flagD), 0);
      chk("rst_width_u", int'(u_fall - u_rise), 30);
      chk("rst_state_u", int'(bus.state_u), int'(IDLE));
      exp_nu++;
      d_before = d_rises;
      #0.5 bus.FB = 1'b1;
      #5 bus.IN = 1'b0;
      #5 bus.IN = 1'b1;
      #5;
      chk("rst_hold_u", int'(bus.flagU), 0);
      chk("rst_hold_d", int'(bus.flagD), 0);
      chk("rst_no_rise_d", d_rises, d_before);
      bus.IN = 1'b0;
      bus.FB = 1'b0;
      #5 RESET_ = 1'b1;
      #5;
      chk("rst_release_u", int'(bus.flagU), 0);
      chk("rst_release_d", int'(bus.flagD), 0);
      tick_en = 1'b0;
      #1000;
      drive_pair(58, 0, 300);
      exp_q.push_back(50);
      exp_q.push_back(108);
      check_pulse("fresh");
`endif

      #1000;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
